matmul_sequencer: RTL and testbench
===================================

MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: element width in bits.
REQ-002 Parameter BUS_WIDTH, default 64: bus width in bits.
REQ-003 Parameter MAX_DIM, default BUS_WIDTH/DATA_WIDTH: max matrix dimension; FLAG_W = MAX_DIM*MAX_DIM; DIM_W = max(1, clog2(MAX_DIM)).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk_i  in  1  rising-edge clock.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 start_i  in  1  one-cycle start request.
REQ-008 abort_i  in  1  cancel the current operation.
REQ-009 n_dim_i, k_dim_i, m_dim_i  in  DIM_W each  dimension minus 1 (0 means 1), sampled with the accepted start.
REQ-010 pe_flags_i  in  FLAG_W  per-PE overflow/underflow flags; bit r*MAX_DIM+c = PE(r,c).
REQ-011 pe_clear_o  out  1  clears PE accumulators.
REQ-012 pe_en_o  out  1  PE grid step enable.
REQ-013 flags_we_o  out  1  write enable to the flags register.
REQ-014 flags_data_o  out  FLAG_W  flag word to write.
REQ-015 busy_o  out  1  high in every state except IDLE.
REQ-016 done_o  out  1  one-cycle completion pulse.

Function
REQ-017 FSM states SHALL be IDLE, CLEAR, RUN, WRITE, DONE; outputs SHALL be registered or decoded from state only.
REQ-018 IDLE: start_i=1 SHALL latch the three dims, clear the flag accumulator, and go to CLEAR; start_i SHALL be ignored in all other states.
REQ-019 CLEAR SHALL last exactly 1 cycle with pe_clear_o=1, pe_en_o=0, then go to RUN.
REQ-020 RUN SHALL last exactly L = n+k+m+1 cycles (latched dims-minus-1 values), with pe_en_o=1 on each; a run counter of width clog2(3*MAX_DIM)+1 SHALL load 0 on entry and exit at count L-1.
REQ-021 Each RUN cycle the accumulator SHALL OR in pe_flags_i AND active-mask, where mask bit r*MAX_DIM+c = 1 iff r<=n and c<=m; bits outside the mask SHALL stay 0.
REQ-022 WRITE SHALL last 1 cycle with flags_we_o=1 and flags_data_o = final accumulator (including the flags from the last RUN cycle); flags_data_o SHALL be 0 whenever flags_we_o=0.
REQ-023 DONE SHALL last 1 cycle with done_o=1, then return to IDLE; start->done latency = L+3 cycles from the start edge.
REQ-024 abort_i=1 in CLEAR or RUN SHALL go to IDLE next cycle with no flags_we_o and no done_o; abort_i in WRITE or DONE SHALL be ignored; abort_i in IDLE is a no-op.
REQ-025 abort_i and start_i high together in IDLE: start SHALL be accepted (abort has no effect in IDLE).
REQ-026 Minimum dims (all 0) SHALL give L=1; maximum dims (all MAX_DIM-1) SHALL give L=3*MAX_DIM-2 with no counter overflow.

Reset
REQ-027 rst_ni low SHALL asynchronously force IDLE, clear the counter, dims, and accumulator, and drive all outputs to 0, including mid-operation; the first start is accepted on the first edge after release.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the DIM_W/FLAG_W derivation function, and the default DATA_WIDTH/BUS_WIDTH constants.
REQ-029 The active-mask generator SHALL be one sub-module, flag_mask_gen (inputs n, m; output FLAG_W mask), combinational.

Verification (MAX_DIM=2)
REQ-030 Start with n=k=m=1 and pe_flags_i=0 -> pe_clear_o 1 cycle, pe_en_o 4 cycles, flags_we_o with data 4'b0000, done_o 7 cycles after the start edge.
REQ-031 n=0, m=1, k=0 with pe_flags_i=4'b1111 throughout RUN -> L=2, flags_data_o=4'b0011 (row 1 masked).
REQ-032 Flag bit 3 pulsed only on the last RUN cycle, n=k=m=1 -> flags_data_o=4'b1000.
REQ-033 abort_i on the 2nd RUN cycle -> IDLE next cycle, busy_o=0, no flags_we_o, no done_o; a new start is then accepted normally.
REQ-034 start_i re-asserted during RUN and WRITE -> ignored, single done_o; rst_ni pulsed low mid-RUN -> all outputs 0 immediately, FSM in IDLE.

Source files
------------

// File: rtl/matmul_sequencer_pkg.sv
// Shared definitions for the matmul sequencer: FSM encoding, default widths
// and the helpers that derive port widths from the grid dimension.
package matmul_sequencer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_BUS_WIDTH  = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_WRITE,
        ST_DONE
    } state_e;

    // A 1x1 grid still needs a 1-bit dimension field.
    function automatic int calc_dim_w(input int max_dim);
        return (max_dim <= 1) ? 1 : $clog2(max_dim);
    endfunction

    function automatic int calc_flag_w(input int max_dim);
        return max_dim * max_dim;
    endfunction

endpackage

// File: rtl/matmul_sequencer_flag_mask_gen.sv
// Combinational mask of the PEs that take part in an n x m product:
// bit r*MAX_DIM+c is set iff r <= n and c <= m.
module flag_mask_gen #(
    parameter int MAX_DIM = 2,
    parameter int DIM_W   = 1,
    parameter int FLAG_W  = MAX_DIM * MAX_DIM
) (
    input  logic [DIM_W-1:0]  n_i,
    input  logic [DIM_W-1:0]  m_i,
    output logic [FLAG_W-1:0] mask_o
);

    logic [MAX_DIM-1:0] row_en;
    logic [MAX_DIM-1:0] col_en;
    logic               row_hit;
    logic               col_hit;

    // Thermometer decode: walking down from the top index, every index at or
    // below the matching one is active.
    always_comb begin
        row_en  = '0;
        col_en  = '0;
        row_hit = 1'b0;
        col_hit = 1'b0;
        for (int i = MAX_DIM - 1; i >= 0; i--) begin
            row_hit   = row_hit | (n_i == DIM_W'(i));
            col_hit   = col_hit | (m_i == DIM_W'(i));
            row_en[i] = row_hit;
            col_en[i] = col_hit;
        end
    end

    for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
        for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
            assign mask_o[r*MAX_DIM+c] = row_en[r] & col_en[c];
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Control sequencer for a systolic matmul PE grid: clears the array, steps it
// for n+k+m+1 cycles while collecting PE flags, writes the flag word, signals done.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH,
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    parameter int FLAG_W     = calc_flag_w(MAX_DIM),
    parameter int DIM_W      = calc_dim_w(MAX_DIM)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DIM_W-1:0]  n_dim_i,
    input  logic [DIM_W-1:0]  k_dim_i,
    input  logic [DIM_W-1:0]  m_dim_i,
    input  logic [FLAG_W-1:0] pe_flags_i,
    output logic              pe_clear_o,
    output logic              pe_en_o,
    output logic              flags_we_o,
    output logic [FLAG_W-1:0] flags_data_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = $clog2(3 * MAX_DIM) + 1;

    state_e             state_q;
    state_e             state_d;
    logic [DIM_W-1:0]   n_q;
    logic [DIM_W-1:0]   k_q;
    logic [DIM_W-1:0]   m_q;
    logic [CNT_W-1:0]   run_cnt_q;
    logic [CNT_W-1:0]   run_last_cnt;
    logic               run_last;
    logic [FLAG_W-1:0]  acc_q;
    logic [FLAG_W-1:0]  active_mask;

    flag_mask_gen #(
        .MAX_DIM (MAX_DIM),
        .DIM_W   (DIM_W),
        .FLAG_W  (FLAG_W)
    ) u_flag_mask_gen (
        .n_i    (n_q),
        .m_i    (m_q),
        .mask_o (active_mask)
    );

    // The wavefront needs n+k+m+1 steps, so the last count is n+k+m.
    assign run_last_cnt = CNT_W'(n_q) + CNT_W'(k_q) + CNT_W'(m_q);
    assign run_last     = (run_cnt_q == run_last_cnt);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            n_q       <= '0;
            k_q       <= '0;
            m_q       <= '0;
            run_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            if (state_q == ST_IDLE && start_i) begin
                n_q   <= n_dim_i;
                k_q   <= k_dim_i;
                m_q   <= m_dim_i;
                acc_q <= '0;
            end
            if (state_q == ST_CLEAR) begin
                run_cnt_q <= '0;
            end
            if (state_q == ST_RUN) begin
                run_cnt_q <= run_cnt_q + CNT_W'(1);
                acc_q     <= acc_q | (pe_flags_i & active_mask);
            end
        end
    end

    // Outputs depend on the current state only; abort is honoured only while
    // the grid is being cleared or stepped.
    always_comb begin
        state_d      = state_q;
        pe_clear_o   = 1'b0;
        pe_en_o      = 1'b0;
        flags_we_o   = 1'b0;
        flags_data_o = '0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                pe_clear_o = 1'b1;
                state_d    = abort_i ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                pe_en_o = 1'b1;
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (run_last) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                flags_we_o   = 1'b1;
                flags_data_o = acc_q;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer (MAX_DIM=2): a cycle-indexed
// reference model checked every cycle, plus directed scenarios with literal results.
module tb_matmul_sequencer;

    localparam int MAX_DIM = 2;
    localparam int DIM_W   = 1;
    localparam int FLAG_W  = 4;

    logic              clk_i;
    logic              rst_ni;
    logic              start_i;
    logic              abort_i;
    logic [DIM_W-1:0]  n_dim_i;
    logic [DIM_W-1:0]  k_dim_i;
    logic [DIM_W-1:0]  m_dim_i;
    logic [FLAG_W-1:0] pe_flags_i;
    logic              pe_clear_o;
    logic              pe_en_o;
    logic              flags_we_o;
    logic [FLAG_W-1:0] flags_data_o;
    logic              busy_o;
    logic              done_o;

    int tests_run = 0;
    int failures  = 0;
    bit cmp_en    = 1'b0;

    matmul_sequencer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .n_dim_i      (n_dim_i),
        .k_dim_i      (k_dim_i),
        .m_dim_i      (m_dim_i),
        .pe_flags_i   (pe_flags_i),
        .pe_clear_o   (pe_clear_o),
        .pe_en_o      (pe_en_o),
        .flags_we_o   (flags_we_o),
        .flags_data_o (flags_data_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: mdl_pos counts edges since the accepted start (0 = idle).
    // pos 1 is the clear cycle, 2..L+1 the run cycles, L+2 write, L+3 done.
    int               mdl_pos = 0;
    int               mdl_len = 1;
    int               mdl_n   = 0;
    int               mdl_m   = 0;
    logic [FLAG_W-1:0] mdl_acc = '0;

    function automatic logic [FLAG_W-1:0] model_mask(input int n, input int m);
        logic [FLAG_W-1:0] msk;
        msk = '0;
        for (int r = 0; r < MAX_DIM; r++)
            for (int c = 0; c < MAX_DIM; c++)
                if (r <= n && c <= m) msk[r*MAX_DIM+c] = 1'b1;
        return msk;
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mdl_pos = 0;
            mdl_acc = '0;
        end else if (mdl_pos == 0) begin
            if (start_i) begin
                mdl_n   = int'(n_dim_i);
                mdl_m   = int'(m_dim_i);
                mdl_len = int'(n_dim_i) + int'(k_dim_i) + int'(m_dim_i) + 1;
                mdl_acc = '0;
                mdl_pos = 1;
            end
        end else if (abort_i && mdl_pos <= mdl_len + 1) begin
            mdl_pos = 0;
        end else begin
            if (mdl_pos >= 2 && mdl_pos <= mdl_len + 1)
                mdl_acc = mdl_acc | (pe_flags_i & model_mask(mdl_n, mdl_m));
            mdl_pos = (mdl_pos == mdl_len + 3) ? 0 : mdl_pos + 1;
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en && rst_ni) begin
            check_output("busy_o", 32'(busy_o), 32'(mdl_pos != 0));
            check_output("pe_clear_o", 32'(pe_clear_o), 32'(mdl_pos == 1));
            check_output("pe_en_o", 32'(pe_en_o), 32'(mdl_pos >= 2 && mdl_pos <= mdl_len + 1));
            check_output("flags_we_o", 32'(flags_we_o), 32'(mdl_pos == mdl_len + 2));
            check_output("flags_data_o", 32'(flags_data_o),
                         32'((mdl_pos == mdl_len + 2) ? mdl_acc : 4'h0));
            check_output("done_o", 32'(done_o), 32'(mdl_pos == mdl_len + 3));
        end
    end

    task automatic check_all_zero(input string tag);
        check_output({tag, " busy_o"}, 32'(busy_o), 32'd0);
        check_output({tag, " pe_clear_o"}, 32'(pe_clear_o), 32'd0);
        check_output({tag, " pe_en_o"}, 32'(pe_en_o), 32'd0);
        check_output({tag, " flags_we_o"}, 32'(flags_we_o), 32'd0);
        check_output({tag, " flags_data_o"}, 32'(flags_data_o), 32'd0);
        check_output({tag, " done_o"}, 32'(done_o), 32'd0);
    endtask

    // One operation: flag_mode 0 = no flags, 1 = all flags high,
    // 2 = only bit 3 on the last run cycle. restart re-asserts start in RUN/WRITE.
    task automatic apply_stimulus(input int n, input int k, input int m, input int flag_mode,
                                  input bit restart, output int done_pos, output int done_cnt,
                                  output int en_cnt, output int clr_cnt,
                                  output logic [FLAG_W-1:0] wdata);
        int len;
        len      = n + k + m + 1;
        done_pos = -1;
        done_cnt = 0;
        en_cnt   = 0;
        clr_cnt  = 0;
        wdata    = '0;
        @(negedge clk_i);
        n_dim_i    = DIM_W'(n);
        k_dim_i    = DIM_W'(k);
        m_dim_i    = DIM_W'(m);
        start_i    = 1'b1;
        pe_flags_i = (flag_mode == 1) ? 4'hF : 4'h0;
        for (int j = 1; j <= len + 6; j++) begin
            @(negedge clk_i);
            if (pe_en_o) en_cnt++;
            if (pe_clear_o) clr_cnt++;
            if (flags_we_o) wdata = flags_data_o;
            if (done_o) begin
                done_cnt++;
                if (done_pos < 0) done_pos = j;
            end
            start_i = restart && (j >= 2) && (j <= len + 2);
            if (flag_mode == 2) pe_flags_i = (j == len + 1) ? 4'h8 : 4'h0;
        end
        start_i    = 1'b0;
        pe_flags_i = '0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int dpos, dcnt, ecnt, ccnt, we_seen;
        logic [FLAG_W-1:0] wd;

        rst_ni     = 1'b0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        n_dim_i    = '0;
        k_dim_i    = '0;
        m_dim_i    = '0;
        pe_flags_i = '0;
        repeat (3) @(negedge clk_i);
        check_all_zero("in_reset");
        rst_ni = 1'b1;
        @(negedge clk_i);
        check_all_zero("after_reset");
        cmp_en = 1'b1;

        $display("[TB] directed: 2x2x2 with no flags");
        apply_stimulus(1, 1, 1, 0, 1'b0, dpos, dcnt, ecnt, ccnt, wd);
        check_output("basic done latency", 32'(dpos), 32'd7);
        check_output("basic pe_en cycles", 32'(ecnt), 32'd4);
        check_output("basic pe_clear cycles", 32'(ccnt), 32'd1);
        check_output("basic flags word", 32'(wd), 32'h0);
        check_output("basic done count", 32'(dcnt), 32'd1);

        $display("[TB] directed: n=0 k=0 m=1, all flags high");
        apply_stimulus(0, 0, 1, 1, 1'b0, dpos, dcnt, ecnt, ccnt, wd);
        check_output("masked done latency", 32'(dpos), 32'd5);
        check_output("masked pe_en cycles", 32'(ecnt), 32'd2);
        check_output("masked flags word", 32'(wd), 32'h3);

        $display("[TB] directed: minimum dims");
        apply_stimulus(0, 0, 0, 1, 1'b0, dpos, dcnt, ecnt, ccnt, wd);
        check_output("min done latency", 32'(dpos), 32'd4);
        check_output("min pe_en cycles", 32'(ecnt), 32'd1);
        check_output("min flags word", 32'(wd), 32'h1);

        $display("[TB] directed: flag bit 3 on last run cycle only");
        apply_stimulus(1, 1, 1, 2, 1'b0, dpos, dcnt, ecnt, ccnt, wd);
        check_output("late flag word", 32'(wd), 32'h8);

        $display("[TB] directed: start re-asserted in RUN and WRITE");
        apply_stimulus(1, 1, 1, 0, 1'b1, dpos, dcnt, ecnt, ccnt, wd);
        check_output("restart done count", 32'(dcnt), 32'd1);
        check_output("restart done latency", 32'(dpos), 32'd7);

        $display("[TB] directed: abort on second run cycle");
        @(negedge clk_i);
        n_dim_i = 1'b1;
        k_dim_i = 1'b1;
        m_dim_i = 1'b1;
        start_i = 1'b1;
        we_seen = 0;
        dcnt    = 0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            if (flags_we_o) we_seen++;
            if (done_o) dcnt++;
            if (j == 4) check_output("abort busy_o", 32'(busy_o), 32'd0);
            abort_i = (j == 3);
        end
        check_output("abort flags_we count", 32'(we_seen), 32'd0);
        check_output("abort done count", 32'(dcnt), 32'd0);
        apply_stimulus(1, 1, 1, 0, 1'b0, dpos, dcnt, ecnt, ccnt, wd);
        check_output("post-abort done latency", 32'(dpos), 32'd7);

        $display("[TB] directed: reset pulse mid-run");
        @(negedge clk_i);
        start_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        #2 rst_ni = 1'b0;
        #1 check_all_zero("mid_run_reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        apply_stimulus(1, 0, 1, 1, 1'b0, dpos, dcnt, ecnt, ccnt, wd);
        check_output("post-reset done latency", 32'(dpos), 32'd6);
        check_output("post-reset flags word", 32'(wd), 32'hF);

        $display("[TB] random phase");
        for (int i = 0; i < 800; i++) begin
            @(negedge clk_i);
            start_i    = ($urandom_range(0, 2) == 0);
            abort_i    = ($urandom_range(0, 9) == 0);
            n_dim_i    = DIM_W'($urandom_range(0, 1));
            k_dim_i    = DIM_W'($urandom_range(0, 1));
            m_dim_i    = DIM_W'($urandom_range(0, 1));
            pe_flags_i = ($urandom_range(0, 3) == 0) ? FLAG_W'($urandom) : 4'h0;
        end
        @(negedge clk_i);
        start_i    = 1'b0;
        abort_i    = 1'b0;
        pe_flags_i = '0;
        repeat (10) @(negedge clk_i);

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
